hs_rx_sink: RTL

Synchronous receiving endpoint for the 4-phase (return-to-zero) bundled-data req/ack pipeline. It terminates the last handshake stage: it synchronises the incoming request, captures the bundled data word, returns the acknowledge, and buffers words in a small FIFO. The FIFO is drained through a valid/ready interface into clocked logic. The block sits at the boundary where the self-timed pipeline feeds the synchronous SoC fabric.

---
 rtl/hs_rx_sink_if.sv | 41 ++++
 rtl/hs_rx_sink.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hs_rx_sink_if.sv
// hs_rx_sink_if: bundles the 4-phase req/ack capture port and the
// valid/ready drain port of hs_rx_sink.
// Optional feature macro: HS_RX_PARITY_EN adds data_par / parity_err.
interface hs_rx_sink_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
`ifdef HS_RX_PARITY_EN
    logic              data_par;
    logic              parity_err;

    modport master (
        output req_in, data_in, data_par, out_ready,
        input  ack_out, out_valid, out_data, level, parity_err
    );

    modport slave (
        input  req_in, data_in, data_par, out_ready,
        output ack_out, out_valid, out_data, level, parity_err
    );
`else
    modport master (
        output req_in, data_in, out_ready,
        input  ack_out, out_valid, out_data, level
    );

    modport slave (
        input  req_in, data_in, out_ready,
        output ack_out, out_valid, out_data, level
    );
`endif
endinterface

// File: rtl/hs_rx_sink.sv
// hs_rx_sink: terminates a 4-phase bundled-data pipeline. The asynchronous
// request is synchronised, the data word is captured on the same edge that
// raises ack_out, and words are buffered in a small FIFO drained through a
// valid/ready port. All outputs come straight from flops.
// Optional feature macro: HS_RX_PARITY_EN (even parity check on data_in;
// a bad word is acknowledged but dropped and parity_err is latched).
module hs_rx_sink #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    hs_rx_sink_if.slave  rx
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // Even parity over a data word (XOR of all bits).
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    state_t                 state_r, state_s;
    logic                   ack_r, ack_s;
    logic                   capture_s;
    logic                   par_ok_s;
    logic                   push_s, pop_s, full_s;
    logic [PTR_W-1:0]       rd_ptr_r, wr_ptr_r, rd_next_s, wr_next_s;
    logic [LVL_W-1:0]       level_r, level_s;
    logic                   out_valid_r;
    logic [DATA_W-1:0]      out_data_r, head_s;
    logic [DATA_W-1:0]      mem_r [DEPTH];

    assign req_s  = sync_r[SYNC_STAGES-1];
    assign full_s = (level_r == LVL_W'(DEPTH));

    // Request synchroniser: shift req_in through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx.req_in};
        end
    end

    // Handshake FSM next state: capture once per 4-phase cycle, stall while full.
    always_comb begin
        state_s   = state_r;
        ack_s     = ack_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (!full_s) begin
                        capture_s = 1'b1;
                        ack_s     = 1'b1;
                        state_s   = ST_ACK;
                    end else begin
                        state_s   = ST_STALL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!full_s) begin
                    capture_s = 1'b1;
                    ack_s     = 1'b1;
                    state_s   = ST_ACK;
                end else begin
                    state_s   = ST_STALL;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACK;
                end
            end
            default: begin
                ack_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

`ifdef HS_RX_PARITY_EN
    assign par_ok_s = (even_par(rx.data_in) == rx.data_par);
`else
    assign par_ok_s = 1'b1;
`endif

    assign push_s = capture_s & par_ok_s;
    assign pop_s  = (level_r != LVL_W'(0)) & rx.out_ready;

    // FIFO bookkeeping: pointer advance, occupancy and the next head word.
    always_comb begin
        rd_next_s = rd_ptr_r;
        wr_next_s = wr_ptr_r;
        level_s   = level_r;
        head_s    = mem_r[rd_ptr_r];
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_next_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_next_s = wr_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVL_W'(1);
            2'b01:   level_s = level_r - LVL_W'(1);
            default: level_s = level_r;
        endcase
        // The slot being written this edge may become the head right away.
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_s = rx.data_in;
        end else begin
            head_s = mem_r[rd_next_s];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            ack_r       <= 1'b0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            level_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            state_r     <= state_s;
            ack_r       <= ack_s;
            rd_ptr_r    <= rd_next_s;
            wr_ptr_r    <= wr_next_s;
            level_r     <= level_s;
            out_valid_r <= (level_s != LVL_W'(0));
            out_data_r  <= head_s;
        end
    end

    // FIFO storage: cleared on reset, written at wr_ptr on a push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= rx.data_in;
        end
    end

`ifdef HS_RX_PARITY_EN
    logic parity_err_r;

    // Sticky parity error: set by a bad word on its capture edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_err_r <= 1'b0;
        end else if (capture_s && !par_ok_s) begin
            parity_err_r <= 1'b1;
        end
    end

    assign rx.parity_err = parity_err_r;
`endif

    assign rx.ack_out   = ack_r;
    assign rx.out_valid = out_valid_r;
    assign rx.out_data  = out_data_r;
    assign rx.level     = level_r;
endmodule
